// File: rtl/rst_seq.sv
// rst_seq: reset consumer with two-flop deassert sync, hold-off,
// staggered per-stage releases and software re-sequence.
module rst_seq #(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGE_GAP   = 2,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sw_rst_req,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  rst_done,
    output logic                  busy,
    output logic [CNT_W-1:0]      sw_rst_count
);
    localparam int MAXC = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int TW   = $clog2(MAXC + 1);
    localparam int IW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        SYNC,
        HOLD,
        REL,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync2_q;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  release_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= 1'b1;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        idx_d       = idx_q;
        stage_d     = stage_q;
        done_d      = done_q;
        cnt_d       = cnt_q;
        release_now = 1'b0;

        unique case (state_q)
            // The edge that sees the synchroniser high already counts as
            // the first hold cycle.
            SYNC: begin
                if (sync2_q) begin
                    if (HOLD_CYCLES == 1) begin
                        release_now = 1'b1;
                    end else begin
                        state_d = HOLD;
                        tmr_d   = TW'(1);
                    end
                end
            end
            HOLD: begin
                if (tmr_q == HOLD_LAST) release_now = 1'b1;
                else                    tmr_d = tmr_q + 1'b1;
            end
            REL: begin
                if (tmr_q == GAP_LAST) release_now = 1'b1;
                else                   tmr_d = tmr_q + 1'b1;
            end
            DONE: begin
                if (sw_rst_req) begin
                    state_d = HOLD;
                    tmr_d   = '0;
                    idx_d   = '0;
                    stage_d = '0;
                    done_d  = 1'b0;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SYNC;
        endcase

        if (release_now) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (idx_q == IW'(k)) stage_d[k] = 1'b1;
            end
            tmr_d = '0;
            if (idx_q == LAST_IDX) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                state_d = REL;
                idx_d   = idx_q + 1'b1;
            end
        end

        busy_d = ~done_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SYNC;
            tmr_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stage_rst_n  = stage_q;
    assign rst_done     = done_q;
    assign busy         = busy_q;
    assign sw_rst_count = cnt_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: scoreboard bench for rst_seq; three instances cover
// default, narrow-counter and single-stage configurations.
module tb_rst_seq;
    typedef struct packed {
        int         cyc;
        logic [2:0] stg;
        logic       done;
        logic       busy;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_a = 1'b0, sw_b = 1'b0, sw_c = 1'b0;
    logic [2:0] a_stg, b_stg;
    logic [0:0] c_stg;
    logic       a_done, b_done, c_done;
    logic       a_busy, b_busy, c_busy;
    logic [7:0] a_cnt, c_cnt;
    logic [1:0] b_cnt;

    logic [1:0] sel = 2'd0;
    logic [2:0] mon_stg;
    logic       mon_done, mon_busy;
    logic [7:0] mon_cnt;

    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    logic [2:0] prev;
    ev_t exp_q[$];
    ev_t obs_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rst_seq u_a (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_a),
        .stage_rst_n(a_stg), .rst_done(a_done), .busy(a_busy),
        .sw_rst_count(a_cnt)
    );

    rst_seq #(.CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_b),
        .stage_rst_n(b_stg), .rst_done(b_done), .busy(b_busy),
        .sw_rst_count(b_cnt)
    );

    rst_seq #(.NUM_STAGES(1), .HOLD_CYCLES(1)) u_c (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_c),
        .stage_rst_n(c_stg), .rst_done(c_done), .busy(c_busy),
        .sw_rst_count(c_cnt)
    );

    assign mon_stg  = (sel == 2'd0) ? a_stg  : (sel == 2'd1) ? b_stg  : {2'b00, c_stg};
    assign mon_done = (sel == 2'd0) ? a_done : (sel == 2'd1) ? b_done : c_done;
    assign mon_busy = (sel == 2'd0) ? a_busy : (sel == 2'd1) ? b_busy : c_busy;
    assign mon_cnt  = (sel == 2'd0) ? a_cnt  : (sel == 2'd1) ? {6'd0, b_cnt} : c_cnt;

    task automatic sample();
        if (mon_stg !== prev)
            obs_q.push_back(ev_t'{cyc, mon_stg, mon_done, mon_busy});
        prev = mon_stg;
    endtask

    task automatic start_watch();
        exp_q.delete();
        obs_q.delete();
        prev = mon_stg;
    endtask

    task automatic test_reset();
        sel = 2'd0;
        rst_n = 1'b0;
        repeat (25) @(negedge clk);
        tests++;
        if ({a_stg, a_done, a_busy, a_cnt} !== {3'b000, 1'b0, 1'b1, 8'd0}) begin
            fails++;
            $display("FAIL reset_a: got stg=%b done=%b busy=%b cnt=%0d, required 000 0 1 0",
                     a_stg, a_done, a_busy, a_cnt);
        end
        tests++;
        if ({b_stg, b_cnt, c_stg, c_done, c_busy} !== {3'b000, 2'd0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_bc: got b=%b/%0d c=%b/%b/%b, required 000/0 0/0/1",
                     b_stg, b_cnt, c_stg, c_done, c_busy);
        end
    endtask

    task automatic test_power_on();
        int e0;
        ev_t e, o;
        sel = 2'd0;
        start_watch();
        rst_n = 1'b1;
        e0 = cyc + 1;
        exp_q.push_back(ev_t'{e0 + 5, 3'b001, 1'b0, 1'b1});
        exp_q.push_back(ev_t'{e0 + 7, 3'b011, 1'b0, 1'b1});
        exp_q.push_back(ev_t'{e0 + 9, 3'b111, 1'b1, 1'b0});
        repeat (14) begin
            @(negedge clk);
            sample();
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL power_on: no event, required %p", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL power_on: got %p, required %p", o, e);
                end
            end
        end
        tests++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL power_on_extra: got %0d extra events, required 0", obs_q.size());
        end
    endtask

    task automatic test_glitch();
        int e0;
        ev_t e, o;
        sel = 2'd0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        start_watch();
        rst_n = 1'b1;
        e0 = cyc + 1;
        exp_q.push_back(ev_t'{e0 + 5, 3'b001, 1'b0, 1'b1});
        repeat (7) begin
            @(negedge clk);
            sample();
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({mon_stg, mon_done, mon_busy} !== {3'b000, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL glitch_async: got stg=%b done=%b busy=%b, required 000 0 1",
                     mon_stg, mon_done, mon_busy);
        end
        #1 rst_n = 1'b1;
        prev = mon_stg;
        e0 = cyc + 1;
        exp_q.push_back(ev_t'{e0 + 5, 3'b001, 1'b0, 1'b1});
        exp_q.push_back(ev_t'{e0 + 7, 3'b011, 1'b0, 1'b1});
        exp_q.push_back(ev_t'{e0 + 9, 3'b111, 1'b1, 1'b0});
        repeat (14) begin
            @(negedge clk);
            sample();
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL glitch: no event, required %p", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL glitch: got %p, required %p", o, e);
                end
            end
        end
        tests++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL glitch_extra: got %0d extra events, required 0", obs_q.size());
        end
    endtask

    task automatic test_ignored_sw();
        int e0;
        ev_t e, o;
        sel = 2'd0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        start_watch();
        rst_n = 1'b1;
        sw_a = 1'b1;
        e0 = cyc + 1;
        exp_q.push_back(ev_t'{e0 + 5, 3'b001, 1'b0, 1'b1});
        exp_q.push_back(ev_t'{e0 + 7, 3'b011, 1'b0, 1'b1});
        exp_q.push_back(ev_t'{e0 + 9, 3'b111, 1'b1, 1'b0});
        repeat (14) begin
            @(negedge clk);
            sample();
            sw_a = (cyc == e0 + 2) || (cyc == e0 + 5);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL ignored_sw: no event, required %p", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL ignored_sw: got %p, required %p", o, e);
                end
            end
        end
        tests++;
        if (obs_q.size() != 0 || mon_cnt !== 8'd0) begin
            fails++;
            $display("FAIL ignored_sw_cnt: got extra=%0d cnt=%0d, required 0 0",
                     obs_q.size(), mon_cnt);
        end
    endtask

    task automatic test_soft_reset();
        int s;
        ev_t e, o;
        sel = 2'd0;
        @(negedge clk);
        start_watch();
        sw_a = 1'b1;
        s = cyc + 1;
        exp_q.push_back(ev_t'{s,     3'b000, 1'b0, 1'b1});
        exp_q.push_back(ev_t'{s + 4, 3'b001, 1'b0, 1'b1});
        exp_q.push_back(ev_t'{s + 6, 3'b011, 1'b0, 1'b1});
        exp_q.push_back(ev_t'{s + 8, 3'b111, 1'b1, 1'b0});
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            sample();
            if (i == 0) begin
                sw_a = 1'b0;
                tests++;
                if (mon_cnt !== 8'd1) begin
                    fails++;
                    $display("FAIL soft_cnt: got %0d, required 1", mon_cnt);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL soft_reset: no event, required %p", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL soft_reset: got %p, required %p", o, e);
                end
            end
        end
        tests++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL soft_extra: got %0d extra events, required 0", obs_q.size());
        end
    endtask

    task automatic test_count_sat();
        int s;
        int k;
        logic [7:0] want;
        sel = 2'd1;
        @(negedge clk);
        tests++;
        if (mon_stg !== 3'b111 || mon_done !== 1'b1) begin
            fails++;
            $display("FAIL sat_start: got stg=%b done=%b, required 111 1", mon_stg, mon_done);
        end
        sw_b = 1'b1;
        s = cyc + 1;
        repeat (40) begin
            @(negedge clk);
            if ((cyc - s) % 9 == 0) begin
                k = (cyc - s) / 9;
                want = (k >= 2) ? 8'd3 : 8'(k + 1);
                tests++;
                if (mon_cnt !== want || mon_stg !== 3'b000) begin
                    fails++;
                    $display("FAIL sat_accept%0d: got cnt=%0d stg=%b, required cnt=%0d stg=000",
                             k, mon_cnt, mon_stg, want);
                end
                if (k == 4) sw_b = 1'b0;
            end
            if ((cyc - s) % 9 == 8) begin
                tests++;
                if (mon_stg !== 3'b111 || mon_done !== 1'b1) begin
                    fails++;
                    $display("FAIL sat_done: got stg=%b done=%b at +%0d, required 111 1",
                             mon_stg, mon_done, cyc - s);
                end
            end
        end
        repeat (10) @(negedge clk);
        tests++;
        if (mon_cnt !== 8'd3 || mon_stg !== 3'b111) begin
            fails++;
            $display("FAIL sat_hold: got cnt=%0d stg=%b, required 3 111", mon_cnt, mon_stg);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (mon_cnt !== 8'd0 || mon_stg !== 3'b000 || mon_busy !== 1'b1) begin
            fails++;
            $display("FAIL sat_clear: got cnt=%0d stg=%b busy=%b, required 0 000 1",
                     mon_cnt, mon_stg, mon_busy);
        end
    endtask

    task automatic test_single_stage();
        int e0;
        ev_t e, o;
        sel = 2'd2;
        repeat (3) @(negedge clk);
        start_watch();
        rst_n = 1'b1;
        e0 = cyc + 1;
        exp_q.push_back(ev_t'{e0 + 2, 3'b001, 1'b1, 1'b0});
        repeat (6) begin
            @(negedge clk);
            sample();
            if (cyc == e0 + 1) begin
                tests++;
                if (mon_busy !== 1'b1 || mon_done !== 1'b0) begin
                    fails++;
                    $display("FAIL single_early: got busy=%b done=%b, required 1 0",
                             mon_busy, mon_done);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL single: no event, required %p", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL single: got %p, required %p", o, e);
                end
            end
        end
        tests++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL single_extra: got %0d extra events, required 0", obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_glitch();
        test_ignored_sw();
        test_soft_reset();
        test_count_sat();
        test_single_stage();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
